// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory controller.
//  - Default geometry (data width, address width, tap window).
//  - FSM state encoding: CLEAR sweeps the array to zero, READY serves requests.
//  - tap_lsb(): bit offset of one tap inside the flattened tap bus.
package dmem_pkg;

  localparam int DMEM_DATA_W   = 24;
  localparam int DMEM_ADDR_W   = 8;
  localparam int DMEM_NUM_TAPS = 3;
  localparam int DMEM_TAP_BASE = 13;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic int tap_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: plain single-port RAM with a synchronous read.
//  clk    in  clock
//  en     in  port enable (read or write this cycle)
//  we     in  1 = write wdata to addr, 0 = read addr into rdata
//  addr   in  word address
//  wdata  in  write data
//  rdata  out registered read data, holds until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WIDTH  = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 1 << DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the storage array has no reset; a reset would turn it into
  // thousands of flops. Initial contents are established by the clear sweep.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory with a sequential clear engine, a valid/ready
// request port with registered read data, and always-current tap outputs.
// Optional feature: define DMEM_PARITY_EN to store an even-parity bit per
// word and add the parity_inj / parity_err ports.
//  clk, rst_n        clock; synchronous active-low reset (starts a clear)
//  req_valid/ready   request handshake; req_ready = READY && !clr_start
//  req_we/addr/wdata request body (1 = write)
//  rsp_valid         one-cycle pulse, read data valid (2 edges after accept)
//  rsp_rdata         read data, held until the next response
//  clr_start         start a full clear (honoured in READY only)
//  busy              clear sweep in progress
//  parity_inj        (DMEM_PARITY_EN) store inverted parity for this write
//  parity_err        (DMEM_PARITY_EN) sticky parity-mismatch flag
//  taps              tap i = mem[TAP_BASE+i] at bits [i*DATA_W +: DATA_W]
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int NUM_TAPS = DMEM_NUM_TAPS,
  parameter int TAP_BASE = DMEM_TAP_BASE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  input  logic                       clr_start,
  output logic                       busy,
`ifdef DMEM_PARITY_EN
  input  logic                       parity_inj,
  output logic                       parity_err,
`endif
  output logic [NUM_TAPS*DATA_W-1:0] taps
);

`ifdef DMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  // Pointer is one bit wider than the address so DEPTH = 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]                state_q, state_d;
  logic [ADDR_W:0]           clr_ptr_q, clr_ptr_d;
  logic                      rd_pend_q, rd_pend_d;   // read issued to the array last edge
  logic                      rd_oor_q, rd_oor_d;     // ...and it was out of range
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic [NUM_TAPS*DATA_W-1:0] taps_q, taps_d;
  logic                      tw_valid_q, tw_valid_d; // write seen last edge, applied to taps now
  logic [ADDR_W-1:0]         tw_addr_q, tw_addr_d;
  logic [DATA_W-1:0]         tw_data_q, tw_data_d;
`ifdef DMEM_PARITY_EN
  logic                      parity_err_q, parity_err_d;
`endif

  logic                      arr_en, arr_we;
  logic [ADDR_W-1:0]         arr_addr;
  logic [MEM_W-1:0]          arr_wdata, arr_rdata;
  logic                      in_range;

  dmem_array #(.WIDTH(MEM_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == ST_READY) && !clr_start;
  assign in_range  = {1'b0, req_addr} < DEPTH_W;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rd_pend_d   = 1'b0;
    rd_oor_d    = 1'b0;
    rsp_valid_d = rd_pend_q;
    rsp_rdata_d = rsp_rdata_q;
    taps_d      = taps_q;
    tw_valid_d  = 1'b0;
    tw_addr_d   = req_addr;
    tw_data_d   = req_wdata;
    arr_en      = 1'b0;
    arr_we      = 1'b0;
    arr_addr    = req_addr;
    arr_wdata   = '0;
`ifdef DMEM_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    // Response stage: the array output belongs to the read issued last edge.
    if (rd_pend_q) begin
      rsp_rdata_d = rd_oor_q ? '0 : arr_rdata[DATA_W-1:0];
`ifdef DMEM_PARITY_EN
      if (!rd_oor_q && (arr_rdata[DATA_W] != (^arr_rdata[DATA_W-1:0])))
        parity_err_d = 1'b1;
`endif
    end

    // Taps follow request writes one edge late. Clear writes need no snoop:
    // taps are zeroed when a clear starts and the sweep only writes zeros.
    if (tw_valid_q) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (tw_addr_q == ADDR_W'(TAP_BASE + i))
          taps_d[tap_lsb(i, DATA_W) +: DATA_W] = tw_data_q;
      end
    end

    case (state_q)
      ST_CLEAR: begin
        arr_en    = 1'b1;
        arr_we    = 1'b1;
        arr_addr  = clr_ptr_q[ADDR_W-1:0];
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = ST_READY;
`ifdef DMEM_PARITY_EN
          parity_err_d = 1'b0;
`endif
        end
      end
      default: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          taps_d    = '0;
        end else if (req_valid) begin
          if (req_we) begin
            arr_en     = in_range;
            arr_we     = in_range;
            tw_valid_d = in_range;
`ifdef DMEM_PARITY_EN
            arr_wdata  = {(^req_wdata) ^ parity_inj, req_wdata};
`else
            arr_wdata  = req_wdata;
`endif
          end else begin
            arr_en    = in_range;
            rd_pend_d = 1'b1;
            rd_oor_d  = !in_range;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      rd_pend_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      taps_q      <= '0;
      tw_valid_q  <= 1'b0;
      tw_addr_q   <= '0;
      tw_data_q   <= '0;
`ifdef DMEM_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rd_pend_q   <= rd_pend_d;
      rd_oor_q    <= rd_oor_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      taps_q      <= taps_d;
      tw_valid_q  <= tw_valid_d;
      tw_addr_q   <= tw_addr_d;
      tw_data_q   <= tw_data_d;
`ifdef DMEM_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign taps      = taps_q;
`ifdef DMEM_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (default geometry: 24-bit words, 256 deep,
// taps at 13..15). A transaction-level model tracks memory contents, the
// clear countdown and pending read responses; a negedge process compares all
// outputs every cycle. Directed sequences add literal expectations.
module tb_dmem_ctrl;

  localparam int DW    = 24;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int NT    = 3;
  localparam int TB    = 13;

  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_we, rsp_valid, clr_start, busy;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata, rsp_rdata;
  logic [NT*DW-1:0] taps;
  logic parity_inj;
`ifdef DMEM_PARITY_EN
  logic parity_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .busy      (busy),
`ifdef DMEM_PARITY_EN
    .parity_inj(parity_inj),
    .parity_err(parity_err),
`endif
    .taps      (taps)
  );

  task automatic check(input string name, input logic [NT*DW-1:0] act, input logic [NT*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint due; logic [DW-1:0] data; bit bad; } rsp_t;
  rsp_t             rsp_q[$];
  logic [DW-1:0]    m_mem [DEPTH];
  bit               m_bad [DEPTH];
  bit               m_started = 0;
  bit               m_clearing;
  int               m_clr_cnt;
  longint           m_cyc = 0;
  logic             exp_rsp_valid;
  logic [DW-1:0]    exp_rsp_rdata;
  logic [NT*DW-1:0] exp_taps, snap;
  logic             exp_perr;

  function automatic void wipe();
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_bad[i] = 0; end
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_started = 1; m_clearing = 1; m_clr_cnt = 0;
      exp_rsp_valid = 0; exp_rsp_rdata = '0; exp_taps = '0; exp_perr = 0;
      rsp_q.delete(); wipe();
    end else if (m_started) begin
      exp_rsp_valid = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due == m_cyc) begin
        rsp_t r;
        r = rsp_q.pop_front();
        exp_rsp_valid = 1; exp_rsp_rdata = r.data;
        if (r.bad) exp_perr = 1;
      end
      exp_taps = snap;  // taps show memory as it was before this edge
      if (m_clearing) begin
        m_clr_cnt++;
        if (m_clr_cnt == DEPTH) begin m_clearing = 0; exp_perr = 0; end
      end else if (clr_start) begin
        m_clearing = 1; m_clr_cnt = 0; exp_taps = '0; wipe();
      end else if (req_valid) begin
        if (req_we) begin
          m_mem[req_addr] = req_wdata;
          m_bad[req_addr] = parity_inj;
        end else begin
          rsp_q.push_back('{m_cyc + 1, m_mem[req_addr], m_bad[req_addr]});
        end
      end
    end
    for (int i = 0; i < NT; i++) snap[i*DW +: DW] = m_mem[TB + i];
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("busy",      {71'b0, busy},      {71'b0, m_clearing});
      check("req_ready", {71'b0, req_ready}, {71'b0, !m_clearing && !clr_start});
      check("rsp_valid", {71'b0, rsp_valid}, {71'b0, exp_rsp_valid});
      check("rsp_rdata", {48'b0, rsp_rdata}, {48'b0, exp_rsp_rdata});
      check("taps",      taps,               exp_taps);
`ifdef DMEM_PARITY_EN
      check("parity_err", {71'b0, parity_err}, {71'b0, exp_perr});
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
    clr_start = 1'b0; parity_inj = 1'b0;
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, a, d); cyc(); idle();
  endtask

  // Read one word and check the response two edges after issue.
  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    drive(1'b1, 1'b0, a, '0); cyc(); idle(); cyc();
    check({name, "_valid"}, {71'b0, rsp_valid}, {71'b0, 1'b1});
    check({name, "_data"},  {48'b0, rsp_rdata}, {48'b0, exp});
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 600) begin cyc(); n++; end
    check(name, 72'(n), 72'(DEPTH));
    check({name, "_ready"}, {71'b0, req_ready}, {71'b0, 1'b1});
  endtask

  logic [DW-1:0] pre [3];

  initial begin
    rst_n = 1'b0; idle();
    // 1: reset and initial sweep
    cyc(); cyc();
    check("rst_busy",  {71'b0, busy},      {71'b0, 1'b1});
    check("rst_ready", {71'b0, req_ready}, {71'b0, 1'b0});
    check("rst_taps",  taps,               '0);
    rst_n = 1'b1;
    wait_clear("init_clear_len");

    // 2: write tap 0 then read it back
    write1(8'h0D, 24'hABCDEF);
    read_chk("rd_0d", 8'h0D, 24'hABCDEF);
    check("tap0", {48'b0, taps[DW-1:0]}, {48'b0, 24'hABCDEF});

    // 3: back-to-back reads give back-to-back responses
    pre[0] = 24'h11; pre[1] = 24'h22; pre[2] = 24'h33;
    for (int i = 0; i < 3; i++) write1(AW'(i + 1), pre[i]);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, 1'b0, AW'(i + 1), '0); else idle();
      cyc();
      if (i >= 1 && i <= 3) begin
        check("b2b_valid", {71'b0, rsp_valid}, {71'b0, 1'b1});
        check("b2b_data",  {48'b0, rsp_rdata}, {48'b0, pre[i-1]});
      end
      if (i == 4) check("b2b_end", {71'b0, rsp_valid}, {71'b0, 1'b0});
    end
    check("b2b_hold", {48'b0, rsp_rdata}, {48'b0, 24'h33});

`ifdef DMEM_PARITY_EN
    // 6: injected parity error is sticky until clear completes
    drive(1'b1, 1'b1, 8'd7, 24'h000001); parity_inj = 1'b1; cyc(); idle();
    read_chk("par_rd", 8'd7, 24'h000001);
    check("par_err", {71'b0, parity_err}, {71'b0, 1'b1});
    repeat (3) cyc();
    check("par_sticky", {71'b0, parity_err}, {71'b0, 1'b1});
    clr_start = 1'b1; cyc(); idle();
    check("par_in_clear", {71'b0, parity_err}, {71'b0, 1'b1});
    wait_clear("par_clear_len");
    check("par_cleared", {71'b0, parity_err}, {71'b0, 1'b0});
`endif

    // 4: clear request wins over a concurrent write
    write1(8'd5, 24'h000099);
    write1(8'h0D, 24'h123456);
    drive(1'b1, 1'b1, 8'd5, 24'h000055); clr_start = 1'b1; #1;
    check("clr_no_ready", {71'b0, req_ready}, {71'b0, 1'b0});
    cyc(); idle();
    check("clr_busy", {71'b0, busy}, {71'b0, 1'b1});
    check("clr_taps", taps, '0);
    wait_clear("clr_len");
    read_chk("clr_rd5",  8'd5,  24'h0);
    read_chk("clr_rd0d", 8'h0D, 24'h0);

    // 5: reset in mid-sweep restarts it
    clr_start = 1'b1; cyc(); idle();
    repeat (99) cyc();
    check("mid_busy", {71'b0, busy}, {71'b0, 1'b1});
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    wait_clear("rst_mid_len");

    // Random traffic, occasionally interrupted by clears
    for (int i = 0; i < 2500; i++) begin
      clr_start  = ($urandom_range(0, 299) == 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = $urandom_range(0, 1) == 1;
      req_addr   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 20)) : AW'($urandom_range(0, 255));
      req_wdata  = DW'($urandom);
      parity_inj = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
